mem_arb_ctrl: RTL

- Two-requester arbitrated controller for a single-port 16x8 register-file memory.
- Serialises read/write commands from two masters through round-robin arbitration with a req/gnt handshake, then returns read data with a valid strobe.
- Sits between two client blocks and the shared storage array; the array is instantiated internally.

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_array.sv | 25 ++
 rtl/mem_arb_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM encoding,
// default geometry and requester indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        RESP   = 2'b10
    } state_t;

    localparam int DW_DEF    = 8;
    localparam int AW_DEF    = 4;
    localparam int DEPTH_DEF = 16;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mem_array.sv
// DEPTH x DW register-file storage: synchronous write, registered read,
// no reset on the array or its read register.
module mem_array #(
    parameter int DW    = 8,
    parameter int AW    = 4,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: storage has no reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/mem_arb_ctrl.sv
// Round-robin arbiter serialising two requesters onto one mem_array.
// Optional grant counters gcnt0/gcnt1 are built when MEM_ARB_GRANT_CNT_EN is defined.
module mem_arb_ctrl
    import mem_arb_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int AW    = AW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          busy
`ifdef MEM_ARB_GRANT_CNT_EN
    ,
    output logic [7:0]    gcnt0,
    output logic [7:0]    gcnt1
`endif
);

    state_t        state;
    logic          last_winner;
    logic          winner_q;
    logic          we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          pick;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;

    // NOTE: give every always_comb output a default first so no latch is inferred.
    always_comb begin
        pick = REQ0;
        if (req1 && (!req0 || last_winner == REQ0)) begin
            pick = REQ1;
        end
    end

    // The array is addressed by the candidate in IDLE so its registered read
    // is ready during ACCESS; afterwards the latched address holds it steady.
    assign mem_addr = (state == IDLE) ? ((pick == REQ1) ? addr1 : addr0) : addr_q;
    // Decoded from the state register, so an async reset kills the write before the edge.
    assign mem_we   = (state == ACCESS) && we_q;

    mem_array #(
        .DW   (DW),
        .AW   (AW),
        .DEPTH(DEPTH)
    ) u_mem (
        .clk  (clk),
        .we   (mem_we),
        .addr (mem_addr),
        .wdata(wdata_q),
        .rdata(mem_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_winner <= REQ1;
            winner_q    <= REQ0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            gnt0        <= 1'b0;
            gnt1        <= 1'b0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            rdata       <= '0;
            busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        winner_q    <= pick;
                        last_winner <= pick;
                        we_q        <= (pick == REQ1) ? we1    : we0;
                        addr_q      <= (pick == REQ1) ? addr1  : addr0;
                        wdata_q     <= (pick == REQ1) ? wdata1 : wdata0;
                        gnt0        <= (pick == REQ0);
                        gnt1        <= (pick == REQ1);
                        busy        <= 1'b1;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    gnt0 <= 1'b0;
                    gnt1 <= 1'b0;
                    if (!we_q) begin
                        rdata   <= mem_rdata;
                        rvalid0 <= (winner_q == REQ0);
                        rvalid1 <= (winner_q == REQ1);
                    end
                    state <= RESP;
                end
                RESP: begin
                    rvalid0 <= 1'b0;
                    rvalid1 <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_GRANT_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gcnt0 <= '0;
            gcnt1 <= '0;
        end else begin
            if (gnt0 && gcnt0 != 8'hFF) gcnt0 <= gcnt0 + 8'd1;
            if (gnt1 && gcnt1 != 8'hFF) gcnt1 <= gcnt1 + 8'd1;
        end
    end
`endif

endmodule
